// File: rtl/bip_control_unit.sv
// bip_control_unit: multi-cycle fetch/decode/exec sequencer for the BIP accumulator processor
module bip_control_unit #(
  parameter int PC_WIDTH      = 11,
  parameter int OPERAND_WIDTH = 11,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     step_mode,
  output logic [PC_WIDTH-1:0]      prog_addr,
  output logic                     prog_req,
  input  logic                     prog_ack,
  input  logic [15:0]              prog_data,
  output logic [OPERAND_WIDTH-1:0] ram_addr,
  output logic                     ram_wr,
  output logic                     ram_rd,
  input  logic                     ram_ack,
  output logic [OPERAND_WIDTH-1:0] operand,
  output logic [1:0]               sel_a,
  output logic                     sel_b,
  output logic                     alu_op,
  output logic                     wr_acc,
  output logic                     wr_pc,
  output logic                     busy,
  output logic                     halted,
  output logic                     illegal,
  output logic [CNT_WIDTH-1:0]     cycle_count,
  output logic [CNT_WIDTH-1:0]     instr_count
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [15:0]            ir_q, ir_d;
  logic [1:0]             sel_a_q, sel_a_d;
  logic                   sel_b_q, sel_b_d, alu_op_q, alu_op_d, illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]   cyc_q, cyc_d, ins_q, ins_d;
  logic [4:0]             opc;
  logic                   mem_op, retire;
  assign opc    = ir_q[15:11];
  assign mem_op = opc inside {5'd1, 5'd2, 5'd4, 5'd6};
  assign retire = (state_q == S_EXEC) && (mem_op ? ram_ack : 1'b1);
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    alu_op_d  = alu_op_q;
    illegal_d = illegal_q;
    ins_d     = ins_q;
    cyc_d     = busy ? (cyc_q == '1 ? cyc_q : cyc_q + 1'b1) : cyc_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ir_d    = prog_ack ? prog_data : ir_q;
        state_d = prog_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        state_d   = (opc == 5'd0 || opc > 5'd7) ? S_HALT : S_EXEC;
        illegal_d = opc > 5'd7;
        sel_a_d   = opc >= 5'd4 ? 2'd2 : (opc == 5'd3 ? 2'd1 : 2'd0);
        sel_b_d   = opc inside {5'd5, 5'd7};
        alu_op_d  = opc inside {5'd6, 5'd7};
      end
      S_EXEC: if (retire) begin
        pc_d    = pc_q + 1'b1;
        ins_d   = ins_q == '1 ? ins_q : ins_q + 1'b1;
        state_d = step_mode ? S_IDLE : S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= 1'b0;
      alu_op_q  <= 1'b0;
      illegal_q <= 1'b0;
      cyc_q     <= '0;
      ins_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end
  assign busy        = state_q inside {S_FETCH, S_DECODE, S_EXEC};
  assign halted      = state_q == S_HALT;
  assign prog_req    = state_q == S_FETCH;
  assign prog_addr   = pc_q;
  assign operand     = ir_q[OPERAND_WIDTH-1:0];
  assign ram_addr    = ir_q[OPERAND_WIDTH-1:0];
  assign ram_wr      = (state_q == S_EXEC) && opc == 5'd1;
  assign ram_rd      = (state_q == S_EXEC) && mem_op && opc != 5'd1;
  assign wr_pc       = retire;
  assign wr_acc      = retire && opc != 5'd1;
  assign sel_a       = sel_a_q;
  assign sel_b       = sel_b_q;
  assign alu_op      = alu_op_q;
  assign illegal     = illegal_q;
  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
endmodule
